neo_frame_ctrl: RTL and testbench
=================================

Name: neo_frame_ctrl

Overview:
- Sequencer and spike detector for the NEO datapath.
- Reads one frame of M signed N-bit samples from a synchronous sample memory and computes psi[n] = x[n]^2 - x[n-1]*x[n+1] for n = 1..M-2, using one shared N×N signed multiplier over two cycles.
- Each psi is compared against a programmable threshold, with a refractory period applied between spikes.
- Sits between the sample buffer and downstream spike-event logic.

Parameters:
- N, 16, sample width (signed two's complement).
- M, 16, samples per frame; minimum 3, elaboration error otherwise.
- REF, 2, refractory length: number of NEO outputs suppressed after a spike; 0 disables suppression.
- CNT_W, 8, spike counter width.
- Derived localparam ADDR_W = $clog2(M).

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, frame start request; sampled only in IDLE.
- abort, input, 1, synchronous abort; returns to IDLE and does not pulse done.
- threshold, input, 2N+1, signed spike threshold; latched on accepted start.
- mem_rd_en, output, 1, sample memory read enable.
- mem_addr, output, ADDR_W, sample address.
- mem_rdata, input, N, sample data; valid in the cycle after mem_rd_en is high.
- neo_valid, output, 1, one-cycle pulse qualifying neo_out, spike and spike_idx.
- neo_out, output, 2N+1, signed psi value.
- spike, output, 1, spike flag, valid only with neo_valid.
- spike_idx, output, ADDR_W, centre sample index n of the current output.
- spike_count, output, CNT_W, spikes detected in the current or last frame; saturates at all-ones.
- busy, output, 1, high while a frame is in progress.
- done, output, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (reset=0): immediate and asynchronous. State=IDLE, window and accumulator registers=0, refractory counter=0, sample counter=0. All outputs 0.
- FSM states: IDLE, FETCH, LOAD, SQ, CROSS, DONE.
- IDLE:
  - start=1 latches threshold, clears spike_count, clears the refractory counter and the sample counter.
  - Next state FETCH.
  - start in any other state is ignored.
- FETCH: mem_rd_en=1, mem_addr=sample counter; both are decodes of registered state. Next state LOAD.
- LOAD:
  - Shift the window: x_prev<=x_cur, x_cur<=x_next, x_next<=mem_rdata. Increment the sample counter.
  - Next state is FETCH while fewer than 3 samples are loaded, else SQ.
- SQ: acc <= x_cur*x_cur (2N-bit signed). Next state CROSS.
- CROSS:
  - neo_out <= sign-extended acc - sign-extended (x_prev*x_next), computed at 2N+1 bits with no overflow possible.
  - spike_idx <= sample counter - 2.
  - neo_valid, spike and spike_count update at the same edge.
  - Next state is FETCH if the sample counter < M, else DONE.
- Spike rule:
  - If the refractory counter = 0 and neo_out > threshold (signed, strict): spike=1, spike_count increments (saturating), refractory counter <= REF.
  - Otherwise spike=0; if the refractory counter is nonzero it decrements once per output.
- DONE: done=1 for one cycle, busy=0. Next state IDLE.
- busy: 1 in FETCH, LOAD, SQ and CROSS.
- Timing, with the start edge as E0:
  - Cycles 1–6 prime three samples.
  - SQ is cycle 7, CROSS is cycle 8, first neo_valid is cycle 9.
  - Each further output takes 4 cycles.
  - The last CROSS is cycle 8+4(M-3); DONE and the last neo_valid fall in the following cycle.
  - For M=16: 14 outputs, busy for cycles 1–60, done in cycle 61.
- abort=1 in any non-IDLE state:
  - Next state IDLE; no further neo_valid and no done.
  - spike_count holds its value.
  - Abort takes priority over all transitions. A neo_valid already registered in the abort cycle stays valid.
- Reset mid-frame: outputs clear asynchronously; no done.
- neo_out, spike_idx and spike hold their values between neo_valid pulses.

Test Plan:
- Ramp x[i]=i, M=16, REF=0, threshold=0:
  - 14 neo_valid pulses, neo_out=1 each, spike_idx=1..14, all spikes, spike_count=14.
  - First neo_valid 9 cycles after start; done in cycle 61.
- Same ramp, REF=2: spikes only at idx 1, 4, 7, 10, 13; spike_count=5.
- Impulse x[5]=100, all other samples 0:
  - neo_out=10000 at idx5; 0 elsewhere, including idx4 and idx6.
  - threshold=9999 gives exactly one spike; threshold=10000 gives none (strict compare).
- Alternating x[even]=32767, x[odd]=-32768:
  - Odd idx: neo_out=+65535. Even idx: neo_out=-65535.
  - threshold=-65536 gives all 14 spikes (REF=0).
  - All samples -32768 gives neo_out=0 everywhere.
- Control edge cases:
  - start pulsed while busy has no effect.
  - abort in cycle 20 gives IDLE next cycle, no done, spike_count unchanged.
  - A restart after abort runs a full correct frame.
- Reset asserted mid-frame at cycle 30: all outputs 0 immediately; no done; the next start behaves as from power-up.

Source files
------------

// File: rtl/neo_frame_ctrl.sv
// neo_frame_ctrl: frame sequencer and NEO spike detector.
// Streams one frame of M signed samples from a synchronous sample memory,
// computes psi[n] = x[n]^2 - x[n-1]*x[n+1] for n = 1..M-2 with one shared
// signed multiplier (x[n]^2 in SQ, x[n-1]*x[n+1] in CROSS), and flags
// spikes where psi exceeds a latched threshold, with a refractory hold-off.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; threshold latched on accepted start
//   S_FETCH | read request for the sample at the sample counter
//   S_LOAD  | shift returned sample into the 3-sample window
//   S_SQ    | acc <= x_cur * x_cur
//   S_CROSS | psi = acc - x_prev * x_next, spike decision, output strobe
//   S_DONE  | one-cycle done pulse, back to idle
module neo_frame_ctrl #(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int REF   = 2,
    parameter int CNT_W = 8
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [2*N:0]     threshold,
    output logic                    mem_rd_en,
    output logic [$clog2(M)-1:0]    mem_addr,
    input  logic signed [N-1:0]     mem_rdata,
    output logic                    neo_valid,
    output logic signed [2*N:0]     neo_out,
    output logic                    spike,
    output logic [$clog2(M)-1:0]    spike_idx,
    output logic [CNT_W-1:0]        spike_count,
    output logic                    busy,
    output logic                    done
);

    localparam int ADDR_W = $clog2(M);
    // one extra bit so the sample counter can reach M itself
    localparam int SC_W   = ADDR_W + 1;
    localparam int REF_W  = (REF > 0) ? $clog2(REF + 1) : 1;

    generate
        if (M < 3) begin : g_bad_m
            $error("neo_frame_ctrl: M must be at least 3");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SQ    = 3'd3,
        S_CROSS = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic signed [2*N:0]   thr;
    logic signed [N-1:0]   x_prev, x_cur, x_next;
    logic signed [2*N-1:0] acc;
    logic [SC_W-1:0]       scnt;
    logic [REF_W-1:0]      refr;

    logic signed [N-1:0]   mul_a, mul_b;
    logic signed [2*N-1:0] prod;
    logic signed [2*N:0]   diff;
    logic                  hit;

    // state register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode; abort overrides every transition out of a busy state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            // scnt is the count before this load; the window is full at 3
            S_LOAD:  state_nxt = (scnt >= SC_W'(2)) ? S_SQ : S_FETCH;
            S_SQ:    state_nxt = S_CROSS;
            S_CROSS: state_nxt = (scnt < SC_W'(M)) ? S_FETCH : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    // shared multiplier operand select and psi / spike decision
    always_comb begin
        mul_a = x_prev;
        mul_b = x_next;
        if (state == S_SQ) begin
            mul_a = x_cur;
            mul_b = x_cur;
        end
        prod = mul_a * mul_b;
        diff = {acc[2*N-1], acc} - {prod[2*N-1], prod};
        hit  = (refr == '0) && (diff > thr);
    end

    // window, accumulator, counters and registered results
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            thr         <= '0;
            x_prev      <= '0;
            x_cur       <= '0;
            x_next      <= '0;
            acc         <= '0;
            scnt        <= '0;
            refr        <= '0;
            neo_valid   <= 1'b0;
            neo_out     <= '0;
            spike       <= 1'b0;
            spike_idx   <= '0;
            spike_count <= '0;
        end else begin
            neo_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thr         <= threshold;
                        spike_count <= '0;
                        refr        <= '0;
                        scnt        <= '0;
                    end
                end
                S_LOAD: begin
                    x_prev <= x_cur;
                    x_cur  <= x_next;
                    x_next <= mem_rdata;
                    scnt   <= scnt + SC_W'(1);
                end
                S_SQ: begin
                    acc <= prod;
                end
                S_CROSS: begin
                    // an abort landing on CROSS produces no further output
                    if (!abort) begin
                        neo_out   <= diff;
                        spike_idx <= scnt[ADDR_W-1:0] - ADDR_W'(2);
                        neo_valid <= 1'b1;
                        spike     <= hit;
                        if (hit) begin
                            refr <= REF_W'(REF);
                            if (spike_count != '1) spike_count <= spike_count + CNT_W'(1);
                        end else if (refr != '0) begin
                            refr <= refr - REF_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = (state == S_FETCH);
    assign mem_addr  = mem_rd_en ? scnt[ADDR_W-1:0] : '0;
    assign busy      = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_SQ)    || (state == S_CROSS);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_neo_frame_ctrl.sv
// Testbench for neo_frame_ctrl: two instances (REF=0 and REF=2) share the
// control inputs and a 16-entry sample table; frames are table-driven,
// with hand-written sequences for busy-start, abort and mid-frame reset.
module tb_neo_frame_ctrl;

    localparam int N = 16;
    localparam int M = 16;
    localparam int AW = 4;

    logic               Clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic signed [32:0] threshold;

    logic               rd_en0, rd_en2;
    logic [AW-1:0]      addr0, addr2;
    logic signed [15:0] rdata0, rdata2;
    logic               nv0, nv2;
    logic signed [32:0] neo0, neo2;
    logic               sp0, sp2;
    logic [AW-1:0]      idx0, idx2;
    logic [7:0]         cnt0, cnt2;
    logic               busy0, busy2;
    logic               done0, done2;

    logic signed [15:0] mem [M];

    int n_checks = 0;
    int n_pass   = 0;

    neo_frame_ctrl #(.N(N), .M(M), .REF(0), .CNT_W(8)) dut0 (
        .Clk(Clk), .reset(reset), .start(start), .abort(abort),
        .threshold(threshold), .mem_rd_en(rd_en0), .mem_addr(addr0),
        .mem_rdata(rdata0), .neo_valid(nv0), .neo_out(neo0), .spike(sp0),
        .spike_idx(idx0), .spike_count(cnt0), .busy(busy0), .done(done0)
    );

    neo_frame_ctrl #(.N(N), .M(M), .REF(2), .CNT_W(8)) dut2 (
        .Clk(Clk), .reset(reset), .start(start), .abort(abort),
        .threshold(threshold), .mem_rd_en(rd_en2), .mem_addr(addr2),
        .mem_rdata(rdata2), .neo_valid(nv2), .neo_out(neo2), .spike(sp2),
        .spike_idx(idx2), .spike_count(cnt2), .busy(busy2), .done(done2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // synchronous sample memories, one read port per instance
    always @(posedge Clk) begin
        if (rd_en0) rdata0 <= mem[addr0];
        if (rd_en2) rdata2 <= mem[addr2];
    end

    typedef struct {
        int     pat;        // 0 ramp, 1 impulse at 5, 2 alternating, 3 all -32768
        longint thr;
        int     exp_cnt0;   // spike_count with REF=0
        int     exp_cnt2;   // spike_count with REF=2
        int     probe_idx;
        longint probe_neo;
    } frame_t;

    frame_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < M; i++) begin
            case (pat)
                0: mem[i] = 16'(i);
                1: mem[i] = (i == 5) ? 16'sd100 : 16'sd0;
                2: mem[i] = (i % 2 == 0) ? 16'sh7FFF : 16'sh8000;
                default: mem[i] = 16'sh8000;
            endcase
        end
    endtask

    function automatic longint psi(input int n);
        return longint'(mem[n]) * longint'(mem[n]) - longint'(mem[n-1]) * longint'(mem[n+1]);
    endfunction

    // pulse start from idle; returns in cycle 1 (first cycle after the start edge)
    task automatic start_frame(input longint thr);
        threshold = 33'(thr);
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input int poke_start);
        int     c, nout0, nout2, ref0, ref2, eidx0, eidx2;
        bit     done_seen, sp_exp;
        longint probe;
        load_pattern(f.pat);
        start_frame(f.thr);
        c = 1; nout0 = 0; nout2 = 0; ref0 = 0; ref2 = 0; eidx0 = 1; eidx2 = 1;
        done_seen = 1'b0; probe = -1;
        while (c <= 90 && !done_seen) begin
            if (c == 1)  chk("busy_c1", longint'(busy0), 1);
            if (c == 60) chk("busy_c60", longint'({busy0, done0}), 2);
            if (nv0) begin
                if (nout0 == 0) chk("first_valid_cycle", c, 9);
                chk("idx0", longint'(idx0), eidx0);
                chk("neo0", longint'(neo0), psi(eidx0));
                sp_exp = (ref0 == 0) && (psi(eidx0) > f.thr);
                chk("spike0", longint'(sp0), longint'(sp_exp));
                if (eidx0 == f.probe_idx) probe = longint'(neo0);
                eidx0++; nout0++;
            end
            if (nv2) begin
                chk("idx2", longint'(idx2), eidx2);
                chk("neo2", longint'(neo2), psi(eidx2));
                sp_exp = (ref2 == 0) && (psi(eidx2) > f.thr);
                chk("spike2", longint'(sp2), longint'(sp_exp));
                if (sp_exp) ref2 = 2;
                else if (ref2 != 0) ref2--;
                eidx2++; nout2++;
            end
            if (done0) begin
                chk("done_cycle", c, 61);
                chk("busy_at_done", longint'(busy0), 0);
                done_seen = 1'b1;
            end
            start = (c == poke_start);
            @(negedge Clk);
            c++;
        end
        start = 1'b0;
        chk("done_seen", longint'(done_seen), 1);
        chk("outputs0", nout0, 14);
        chk("outputs2", nout2, 14);
        chk("count_ref0", longint'(cnt0), f.exp_cnt0);
        chk("count_ref2", longint'(cnt2), f.exp_cnt2);
        chk("probe_neo", probe, f.probe_neo);
        chk("done_pulse_len", longint'(done0), 0);
    endtask

    initial begin
        int dcount, bcount;
        tbl[0] = '{pat: 0, thr: 0,      exp_cnt0: 14, exp_cnt2: 5, probe_idx: 7, probe_neo: 1};
        tbl[1] = '{pat: 0, thr: 1,      exp_cnt0: 0,  exp_cnt2: 0, probe_idx: 1, probe_neo: 1};
        tbl[2] = '{pat: 1, thr: 9999,   exp_cnt0: 1,  exp_cnt2: 1, probe_idx: 5, probe_neo: 10000};
        tbl[3] = '{pat: 1, thr: 10000,  exp_cnt0: 0,  exp_cnt2: 0, probe_idx: 6, probe_neo: 0};
        tbl[4] = '{pat: 2, thr: -65536, exp_cnt0: 14, exp_cnt2: 5, probe_idx: 3, probe_neo: 65535};
        tbl[5] = '{pat: 2, thr: -65536, exp_cnt0: 14, exp_cnt2: 5, probe_idx: 4, probe_neo: -65535};
        tbl[6] = '{pat: 3, thr: -1,     exp_cnt0: 14, exp_cnt2: 5, probe_idx: 8, probe_neo: 0};

        reset = 1'b0; start = 1'b0; abort = 1'b0; threshold = '0;
        load_pattern(0);
        repeat (3) @(negedge Clk);
        chk("reset_outputs0", longint'({rd_en0, addr0, nv0, neo0, sp0, idx0, cnt0, busy0, done0}), 0);
        chk("reset_outputs2", longint'({rd_en2, addr2, nv2, neo2, sp2, idx2, cnt2, busy2, done2}), 0);
        reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], 0);

        // start pulsed mid-frame must not disturb the running frame
        run_frame(tbl[0], 22);

        // abort during cycle 20 (a CROSS cycle): idle next cycle, no output, no done
        load_pattern(0);
        start_frame(0);
        repeat (19) @(negedge Clk);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("abort_idle", longint'({busy0, nv0}), 0);
        chk("abort_count0", longint'(cnt0), 3);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            if (done0 || nv0) dcount++;
            @(negedge Clk);
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_count_hold", longint'(cnt0), 3);

        // restart after abort
        run_frame(tbl[0], 0);

        // asynchronous reset in cycle 30
        load_pattern(0);
        start_frame(0);
        repeat (29) @(negedge Clk);
        chk("pre_reset_count", longint'(cnt0), 6);
        reset = 1'b0;
        #1;
        chk("midreset_outputs0", longint'({rd_en0, addr0, nv0, neo0, sp0, idx0, cnt0, busy0, done0}), 0);
        chk("midreset_outputs2", longint'({rd_en2, addr2, nv2, neo2, sp2, idx2, cnt2, busy2, done2}), 0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        dcount = 0; bcount = 0;
        for (int i = 0; i < 60; i++) begin
            if (done0) dcount++;
            if (busy0) bcount++;
            @(negedge Clk);
        end
        chk("reset_no_done", dcount, 0);
        chk("reset_stays_idle", bcount, 0);
        run_frame(tbl[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
